cache_mem_arbiter: RTL and testbench

Shares the single line-wide external memory port between the L1 instruction cache and the L1 data cache. Each cache issues line-fill (and, for the D-cache, line write-back) requests with a strobe/ready handshake. The arbiter grants one requester at a time, registers its command onto the memory port, and routes the memory's ready and line data back to the granted cache only. It sits between the two L1 caches and the memory/bus adapter.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_mem_arbiter_arb_select.sv | 35 +++
 rtl/cache_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache / memory arbiter slice.
// Holds FSM encodings, grant bit indices and line-offset helpers.
package cache_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_I = 2'd1;
    localparam logic [1:0] ARB_GNT_D = 2'd2;
    localparam logic [1:0] ARB_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ARB_IDLE,
        ST_GNT_I = ARB_GNT_I,
        ST_GNT_D = ARB_GNT_D,
        ST_DONE  = ARB_DONE
    } arb_state_e;

    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    localparam int LINE_SIZE_DEF = 256;
    localparam int LINE_OFF_BITS = $clog2(LINE_SIZE_DEF / 8);

    // Byte-offset bits within a line of the given width in bits.
    function automatic int line_off_bits(input int line_size);
        return $clog2(line_size / 8);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_select.sv
// Two-input one-hot arbiter; ARB_RR_EN selects round-robin tie breaking,
// otherwise the D-cache (req[1]) wins every tie.
module arb_select (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifndef ARB_RR_EN
    logic unused_last_s;
    assign unused_last_s = last;
`endif

    // Winner selection; last = 1 means the D-cache was served most recently.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
`ifdef ARB_RR_EN
                if (last) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
`else
                gnt = 2'b10;
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the L1 I-cache and D-cache.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed D-priority.
import cache_pkg::*;

module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_strobe_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ready_o,
    output logic [LINE_SIZE-1:0]  i_data_o,
    input  logic                  d_strobe_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic                  d_rw_i,
    input  logic [LINE_SIZE-1:0]  d_data_i,
    output logic                  d_ready_o,
    output logic [LINE_SIZE-1:0]  d_data_o,
    output logic                  m_strobe_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic                  m_rw_o,
    output logic [LINE_SIZE-1:0]  m_data_o,
    input  logic                  m_ready_i,
    input  logic [LINE_SIZE-1:0]  m_data_i,
    output logic [1:0]            grant_o
);

    localparam int                    OFF_BITS   = line_off_bits(LINE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [1:0]            sel_s;
    logic                  last_s;
    logic                  m_strobe_r;
    logic [ADDR_WIDTH-1:0] m_addr_r;
    logic                  m_rw_r;
    logic [LINE_SIZE-1:0]  m_data_r;
    logic [1:0]            grant_r;

`ifdef ARB_RR_EN
    logic last_r;

    // Remember who was served; captured as the transfer completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_r <= 1'b0;
        end else if (((state_r == ST_GNT_I) || (state_r == ST_GNT_D)) && m_ready_i) begin
            last_r <= (state_r == ST_GNT_D);
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    assign last_s = 1'b0;
`endif

    arb_select u_arb_select (
        .req  ({d_strobe_i, i_strobe_i}),
        .last (last_s),
        .gnt  (sel_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE swallows the requester's lingering strobe.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_s[GNT_D]) begin
                    state_nxt_s = ST_GNT_D;
                end else if (sel_s[GNT_I]) begin
                    state_nxt_s = ST_GNT_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (m_ready_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command latch: captured on grant, held while granted, cleared on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_strobe_r <= 1'b0;
            m_addr_r   <= {ADDR_WIDTH{1'b0}};
            m_rw_r     <= 1'b0;
            m_data_r   <= {LINE_SIZE{1'b0}};
            grant_r    <= 2'b00;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_GNT_D)) begin
            m_strobe_r <= 1'b1;
            m_addr_r   <= d_addr_i & ALIGN_MASK;
            m_rw_r     <= d_rw_i;
            m_data_r   <= d_data_i;
            grant_r    <= 2'b10;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_GNT_I)) begin
            m_strobe_r <= 1'b1;
            m_addr_r   <= i_addr_i & ALIGN_MASK;
            m_rw_r     <= 1'b0;
            m_data_r   <= {LINE_SIZE{1'b0}};
            grant_r    <= 2'b01;
        end else if (state_nxt_s == ST_DONE) begin
            m_strobe_r <= 1'b0;
            m_addr_r   <= {ADDR_WIDTH{1'b0}};
            m_rw_r     <= 1'b0;
            m_data_r   <= {LINE_SIZE{1'b0}};
            grant_r    <= 2'b00;
        end else begin
            m_strobe_r <= m_strobe_r;
            m_addr_r   <= m_addr_r;
            m_rw_r     <= m_rw_r;
            m_data_r   <= m_data_r;
            grant_r    <= grant_r;
        end
    end

    assign m_strobe_o = m_strobe_r;
    assign m_addr_o   = m_addr_r;
    assign m_rw_o     = m_rw_r;
    assign m_data_o   = m_data_r;
    assign grant_o    = grant_r;

    // Completion is routed only to the current owner, with no added latency.
    assign i_ready_o = m_ready_i & (state_r == ST_GNT_I);
    assign d_ready_o = m_ready_i & (state_r == ST_GNT_D);
    assign i_data_o  = i_ready_o ? m_data_i : {LINE_SIZE{1'b0}};
    assign d_data_o  = d_ready_o ? m_data_i : {LINE_SIZE{1'b0}};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (default or ARB_RR_EN build).
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LS = 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          i_strobe_i = 1'b0;
    logic [AW-1:0] i_addr_i = '0;
    logic          i_ready_o;
    logic [LS-1:0] i_data_o;
    logic          d_strobe_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic          d_rw_i = 1'b0;
    logic [LS-1:0] d_data_i = '0;
    logic          d_ready_o;
    logic [LS-1:0] d_data_o;
    logic          m_strobe_o;
    logic [AW-1:0] m_addr_o;
    logic          m_rw_o;
    logic [LS-1:0] m_data_o;
    logic          m_ready_i = 1'b0;
    logic [LS-1:0] m_data_i = '0;
    logic [1:0]    grant_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [LS-1:0] pat1;
    logic [LS-1:0] pat2;
    logic [LS-1:0] pat_a5;
    logic [LS-1:0] zero_line;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_strobe_i(i_strobe_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o), .i_data_o(i_data_o),
        .d_strobe_i(d_strobe_i), .d_addr_i(d_addr_i), .d_rw_i(d_rw_i), .d_data_i(d_data_i),
        .d_ready_o(d_ready_o), .d_data_o(d_data_o),
        .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o), .m_data_o(m_data_o),
        .m_ready_i(m_ready_i), .m_data_i(m_data_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (m_strobe_o !== 1'b0) $display("FAIL rst_m_strobe got %b exp 0", m_strobe_o); else pass_cnt++;
        total_cnt++; if (grant_o !== 2'b00) $display("FAIL rst_grant got %b exp 00", grant_o); else pass_cnt++;
        total_cnt++; if (m_addr_o !== 32'h0) $display("FAIL rst_m_addr got %h exp 0", m_addr_o); else pass_cnt++;
        total_cnt++; if ({i_ready_o, d_ready_o, m_rw_o} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {i_ready_o, d_ready_o, m_rw_o}); else pass_cnt++;
        total_cnt++; if ((m_data_o | i_data_o | d_data_o) !== zero_line) $display("FAIL rst_data got nonzero exp 0"); else pass_cnt++;
        step();
        rst_i = 1'b0;
        step();
        total_cnt++; if (grant_o !== 2'b00) $display("FAIL post_rst_grant got %b exp 00", grant_o); else pass_cnt++;
    endtask

    task automatic test_i_miss();
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h8000_1234;
        step();
        total_cnt++; if (m_strobe_o !== 1'b1) $display("FAIL imiss_m_strobe got %b exp 1", m_strobe_o); else pass_cnt++;
        total_cnt++; if (m_addr_o !== 32'h8000_1220) $display("FAIL imiss_m_addr got %h exp 80001220", m_addr_o); else pass_cnt++;
        total_cnt++; if (m_rw_o !== 1'b0) $display("FAIL imiss_m_rw got %b exp 0", m_rw_o); else pass_cnt++;
        total_cnt++; if (grant_o !== 2'b01) $display("FAIL imiss_grant got %b exp 01", grant_o); else pass_cnt++;
        total_cnt++; if (m_data_o !== zero_line) $display("FAIL imiss_m_data got %h exp 0", m_data_o); else pass_cnt++;
        m_data_i  = pat1;
        m_ready_i = 1'b1;
        #1;
        total_cnt++; if (i_ready_o !== 1'b1) $display("FAIL imiss_i_ready got %b exp 1", i_ready_o); else pass_cnt++;
        total_cnt++; if (i_data_o !== pat1) $display("FAIL imiss_i_data got %h exp %h", i_data_o, pat1); else pass_cnt++;
        total_cnt++; if (d_ready_o !== 1'b0) $display("FAIL imiss_d_ready got %b exp 0", d_ready_o); else pass_cnt++;
        total_cnt++; if (d_data_o !== zero_line) $display("FAIL imiss_d_data got %h exp 0", d_data_o); else pass_cnt++;
        step();
        m_ready_i = 1'b0;
        total_cnt++; if ({m_strobe_o, grant_o} !== 3'b000) $display("FAIL linger_done got %b exp 000", {m_strobe_o, grant_o}); else pass_cnt++;
        step();
        i_strobe_i = 1'b0;
        total_cnt++; if ({m_strobe_o, grant_o} !== 3'b000) $display("FAIL linger_idle got %b exp 000", {m_strobe_o, grant_o}); else pass_cnt++;
        step();
        total_cnt++; if ({m_strobe_o, grant_o} !== 3'b000) $display("FAIL linger_no_regrant got %b exp 000", {m_strobe_o, grant_o}); else pass_cnt++;
    endtask

    task automatic test_d_writeback();
        d_rw_i     = 1'b1;
        d_addr_i   = 32'h8000_0040;
        d_data_i   = pat_a5;
        d_strobe_i = 1'b1;
        step();
        total_cnt++; if (grant_o !== 2'b10) $display("FAIL dwb_grant got %b exp 10", grant_o); else pass_cnt++;
        total_cnt++; if (m_rw_o !== 1'b1) $display("FAIL dwb_m_rw got %b exp 1", m_rw_o); else pass_cnt++;
        total_cnt++; if (m_addr_o !== 32'h8000_0040) $display("FAIL dwb_m_addr got %h exp 80000040", m_addr_o); else pass_cnt++;
        total_cnt++; if (m_data_o !== pat_a5) $display("FAIL dwb_m_data got %h exp %h", m_data_o, pat_a5); else pass_cnt++;
        d_addr_i = 32'h1234_5678;
        d_data_i = '0;
        d_rw_i   = 1'b0;
        step();
        total_cnt++; if ({m_addr_o, m_rw_o} !== {32'h8000_0040, 1'b1}) $display("FAIL dwb_latched got %h/%b exp 80000040/1", m_addr_o, m_rw_o); else pass_cnt++;
        total_cnt++; if (m_data_o !== pat_a5) $display("FAIL dwb_latched_data got %h exp %h", m_data_o, pat_a5); else pass_cnt++;
        m_data_i  = pat2;
        m_ready_i = 1'b1;
        #1;
        total_cnt++; if ({d_ready_o, i_ready_o} !== 2'b10) $display("FAIL dwb_ready got %b exp 10", {d_ready_o, i_ready_o}); else pass_cnt++;
        total_cnt++; if (d_data_o !== pat2) $display("FAIL dwb_d_data got %h exp %h", d_data_o, pat2); else pass_cnt++;
        total_cnt++; if (i_data_o !== zero_line) $display("FAIL dwb_i_data got %h exp 0", i_data_o); else pass_cnt++;
        step();
        m_ready_i = 1'b0;
        step();
        d_strobe_i = 1'b0;
        step();
    endtask

    task automatic test_tie();
        logic [1:0] exp_g [3];
        int i_done;
        int d_done;
`ifdef ARB_RR_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`endif
        i_done = 0;
        d_done = 0;
        i_addr_i   = 32'h0000_1000;
        d_addr_i   = 32'h0000_2000;
        d_rw_i     = 1'b0;
        i_strobe_i = 1'b1;
        d_strobe_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            for (int k = 0; k < 6 && m_strobe_o !== 1'b1; k++) step();
            total_cnt++; if (m_strobe_o !== 1'b1) $display("FAIL tie_timeout round %0d got m_strobe %b exp 1", r, m_strobe_o); else pass_cnt++;
            total_cnt++; if (grant_o !== exp_g[r]) $display("FAIL tie_grant round %0d got %b exp %b", r, grant_o, exp_g[r]); else pass_cnt++;
            m_data_i  = pat1;
            m_ready_i = 1'b1;
            #1;
            if (i_ready_o === 1'b1) i_done++;
            if (d_ready_o === 1'b1) d_done++;
            step();
            m_ready_i = 1'b0;
            step();
            if (r == 1) begin
                if (exp_g[r] == 2'b10) d_strobe_i = 1'b0;
                else i_strobe_i = 1'b0;
            end else if (r == 2) begin
                i_strobe_i = 1'b0;
                d_strobe_i = 1'b0;
            end
        end
        total_cnt++; if (i_done !== 1) $display("FAIL tie_i_completions got %0d exp 1", i_done); else pass_cnt++;
        total_cnt++; if (d_done !== 2) $display("FAIL tie_d_completions got %0d exp 2", d_done); else pass_cnt++;
        step();
        total_cnt++; if ({m_strobe_o, grant_o} !== 3'b000) $display("FAIL tie_idle_after got %b exp 000", {m_strobe_o, grant_o}); else pass_cnt++;
    endtask

    task automatic test_stray_and_reset();
        m_data_i  = pat2;
        m_ready_i = 1'b1;
        #1;
        total_cnt++; if ({i_ready_o, d_ready_o} !== 2'b00) $display("FAIL stray_ready got %b exp 00", {i_ready_o, d_ready_o}); else pass_cnt++;
        total_cnt++; if ((i_data_o | d_data_o) !== zero_line) $display("FAIL stray_data got nonzero exp 0"); else pass_cnt++;
        step();
        m_ready_i = 1'b0;
        total_cnt++; if ({m_strobe_o, grant_o} !== 3'b000) $display("FAIL stray_idle got %b exp 000", {m_strobe_o, grant_o}); else pass_cnt++;
        d_strobe_i = 1'b1;
        d_rw_i     = 1'b1;
        d_addr_i   = 32'h4000_1000;
        d_data_i   = pat_a5;
        step();
        total_cnt++; if (grant_o !== 2'b10) $display("FAIL rstmid_grant got %b exp 10", grant_o); else pass_cnt++;
        #2;
        rst_i = 1'b1;
        #1;
        total_cnt++; if ({m_strobe_o, grant_o, m_rw_o} !== 4'b0000) $display("FAIL rstmid_async got %b exp 0000", {m_strobe_o, grant_o, m_rw_o}); else pass_cnt++;
        total_cnt++; if ({m_addr_o, m_data_o} !== {32'h0, zero_line}) $display("FAIL rstmid_cmd got nonzero exp 0"); else pass_cnt++;
        d_strobe_i = 1'b0;
        d_rw_i     = 1'b0;
        step();
        step();
        rst_i     = 1'b0;
        m_ready_i = 1'b1;
        #1;
        total_cnt++; if ({d_ready_o, i_ready_o} !== 2'b00) $display("FAIL late_ready got %b exp 00", {d_ready_o, i_ready_o}); else pass_cnt++;
        step();
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h0000_00FF;
        step();
        total_cnt++; if (grant_o !== 2'b01) $display("FAIL post_rst_i_grant got %b exp 01", grant_o); else pass_cnt++;
        total_cnt++; if (m_addr_o !== 32'h0000_00E0) $display("FAIL post_rst_i_addr got %h exp 000000e0", m_addr_o); else pass_cnt++;
        m_data_i  = pat1;
        m_ready_i = 1'b1;
        #1;
        total_cnt++; if ({i_ready_o, i_data_o} !== {1'b1, pat1}) $display("FAIL post_rst_i_done got %b exp 1", i_ready_o); else pass_cnt++;
        step();
        m_ready_i = 1'b0;
        step();
        i_strobe_i = 1'b0;
        step();
    endtask

    initial begin
        pat1      = {8{32'hDEAD_BEEF}};
        pat2      = {4{64'h0123_4567_89AB_CDEF}};
        pat_a5    = {32{8'hA5}};
        zero_line = '0;
        test_reset();
        test_i_miss();
        test_d_writeback();
        test_tie();
        test_stray_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
